// File: rtl/yauart_apb_pkg.sv
// yauart_apb_pkg: shared APB requester state encoding and default bus widths
package yauart_apb_pkg;
   localparam int APB_AW = 32;
   localparam int APB_DW = 32;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_state_e;
endpackage

// File: rtl/apb3_master.sv
// apb3_master: single-outstanding APB3 requester with valid/ready command and response streams
//   command:  i_cmd_valid/o_cmd_ready, i_cmd_write, i_cmd_addr, i_cmd_wdata
//   response: o_rsp_valid/i_rsp_ready, o_rsp_rdata, o_rsp_slverr, o_rsp_timeout
//   APB3:     o_apb_paddr/pwdata/pwrite/psel/penable, i_apb_prdata/pready/pslverr
//   TIMEOUT_CYCLES ACCESS cycles without PREADY abort the transfer (0 disables)
module apb3_master
   import yauart_apb_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = APB_AW,
   parameter int APB_DATA_WIDTH = APB_DW,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      i_apb_pclk,
   input  logic                      i_apb_prst,
   input  logic                      i_cmd_valid,
   output logic                      o_cmd_ready,
   input  logic                      i_cmd_write,
   input  logic [APB_ADDR_WIDTH-1:0] i_cmd_addr,
   input  logic [APB_DATA_WIDTH-1:0] i_cmd_wdata,
   output logic                      o_rsp_valid,
   input  logic                      i_rsp_ready,
   output logic [APB_DATA_WIDTH-1:0] o_rsp_rdata,
   output logic                      o_rsp_slverr,
   output logic                      o_rsp_timeout,
   output logic [APB_ADDR_WIDTH-1:0] o_apb_paddr,
   output logic [APB_DATA_WIDTH-1:0] o_apb_pwdata,
   output logic                      o_apb_pwrite,
   output logic                      o_apb_psel,
   output logic                      o_apb_penable,
   input  logic [APB_DATA_WIDTH-1:0] i_apb_prdata,
   input  logic                      i_apb_pready,
   input  logic                      i_apb_pslverr
);
   // a zero timeout still needs a 1-bit counter so the design elaborates
   localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
   apb_mst_state_e state;
   logic [TW-1:0] tcnt;
   logic expire;
   // PREADY has priority over an expiring counter
   assign expire = (TIMEOUT_CYCLES != 0) && (tcnt == TLIM) && !i_apb_pready;
   always_ff @(posedge i_apb_pclk or posedge i_apb_prst) begin
      if (i_apb_prst) begin
         state         <= IDLE;
         tcnt          <= '0;
         o_cmd_ready   <= 1'b1;
         o_rsp_valid   <= 1'b0;
         o_rsp_rdata   <= '0;
         o_rsp_slverr  <= 1'b0;
         o_rsp_timeout <= 1'b0;
         o_apb_paddr   <= '0;
         o_apb_pwdata  <= '0;
         o_apb_pwrite  <= 1'b0;
         o_apb_psel    <= 1'b0;
         o_apb_penable <= 1'b0;
      end else begin
         case (state)
            IDLE: if (i_cmd_valid) begin
               o_apb_paddr  <= i_cmd_addr;
               o_apb_pwdata <= i_cmd_wdata;
               o_apb_pwrite <= i_cmd_write;
               o_apb_psel   <= 1'b1;
               o_cmd_ready  <= 1'b0;
               state        <= SETUP;
            end
            SETUP: begin
               o_apb_penable <= 1'b1;
               tcnt          <= '0;
               state         <= ACCESS;
            end
            ACCESS: if (i_apb_pready || expire) begin
               o_rsp_rdata   <= (i_apb_pready && !o_apb_pwrite) ? i_apb_prdata : '0;
               o_rsp_slverr  <= i_apb_pready ? i_apb_pslverr : 1'b1;
               o_rsp_timeout <= !i_apb_pready;
               o_rsp_valid   <= 1'b1;
               o_apb_psel    <= 1'b0;
               o_apb_penable <= 1'b0;
               state         <= RESP;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
            RESP: if (i_rsp_ready) begin
               o_rsp_valid <= 1'b0;
               o_cmd_ready <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_apb3_master.sv
// tb_apb3_master: directed self-checking bench for apb3_master
module tb_apb3_master;
   logic        clk = 1'b0, rst = 1'b1;
   logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
   logic [31:0] cmd_addr = 0, cmd_wdata = 0;
   logic        rsp_valid, rsp_ready = 0;
   logic [31:0] rsp_rdata;
   logic        rsp_slverr, rsp_timeout;
   logic [31:0] paddr, pwdata;
   logic        pwrite, psel, penable;
   logic [31:0] prdata = 0;
   logic        pready = 0, pslverr = 0;
   int n_checks = 0, n_errors = 0;
   int n_acc;
   logic [31:0] last_wdata, held;
   apb3_master #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
      .i_apb_pclk(clk), .i_apb_prst(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
      .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
      .o_rsp_slverr(rsp_slverr), .o_rsp_timeout(rsp_timeout),
      .o_apb_paddr(paddr), .o_apb_pwdata(pwdata), .o_apb_pwrite(pwrite),
      .o_apb_psel(psel), .o_apb_penable(penable),
      .i_apb_prdata(prdata), .i_apb_pready(pready), .i_apb_pslverr(pslverr)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // waits < 0: the slave never asserts PREADY
   task automatic xfer(input string tag, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int waits, input logic [31:0] rd, input logic err, output int acc);
      logic stable = 1'b1;
      cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
      tick();
      cmd_valid = 0; cmd_addr = 32'h5555_5555; cmd_wdata = 32'h6666_6666; cmd_write = ~wr;
      check({tag, "_c1_psel"}, {psel, penable, cmd_ready}, 3'b100);
      tick();
      check({tag, "_c2_penable"}, {psel, penable}, 2'b11);
      acc = 0;
      for (int k = 0; k < 64; k++) begin
         if (!(psel && penable)) break;
         acc++;
         if (paddr !== addr || pwrite !== wr || (wr && pwdata !== wdata)) stable = 1'b0;
         pready  = (waits >= 0) && (acc == waits + 1);
         prdata  = pready ? rd : 32'h1111_1111;
         pslverr = pready ? err : 1'b1;
         if (pready && wr) last_wdata = pwdata;
         tick();
         pready = 0; pslverr = 0;
      end
      check({tag, "_stable"}, stable, 1'b1);
      check({tag, "_rsp"}, {rsp_valid, psel, penable}, 3'b100);
   endtask
   task automatic take(input string tag);
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
      check({tag, "_take"}, {rsp_valid, cmd_ready}, 2'b01);
   endtask
   initial begin
      tick(); tick();
      check("rst_ctl", {cmd_ready, rsp_valid, psel, penable, pwrite}, 5'b10000);
      check("rst_bus", {paddr, pwdata}, 64'h0);
      check("rst_rsp", {rsp_rdata, rsp_slverr, rsp_timeout}, 34'h0);
      rst = 0;
      tick();
      check("idle_ready", cmd_ready, 1'b1);
      // zero-wait write
      xfer("zw", 1, 32'h04, 32'h0000_00A5, 0, 32'h0, 0, n_acc);
      check("zw_cycle", 2 + n_acc, 3);
      check("zw_fields", {rsp_rdata, rsp_slverr, rsp_timeout}, 34'h0);
      take("zw");
      // three wait states, read
      xfer("ws", 0, 32'h08, 32'h0, 3, 32'hDEAD_BEEF, 0, n_acc);
      check("ws_cycle", 2 + n_acc, 6);
      check("ws_fields", {rsp_rdata, rsp_slverr, rsp_timeout}, {32'hDEAD_BEEF, 2'b00});
      take("ws");
      // slave error
      xfer("se", 0, 32'hFC, 32'h0, 0, 32'h0000_0055, 1, n_acc);
      check("se_fields", {rsp_slverr, rsp_timeout}, 2'b10);
      take("se");
      // timeout with PREADY never asserted
      xfer("to", 0, 32'h10, 32'h0, -1, 32'h0, 0, n_acc);
      check("to_acc", n_acc, 16);
      check("to_fields", {rsp_rdata, rsp_slverr, rsp_timeout}, {32'h0, 2'b11});
      take("to");
      // PREADY on the 16th ACCESS cycle beats the timeout
      xfer("tb", 0, 32'h14, 32'h0, 15, 32'h0BAD_F00D, 0, n_acc);
      check("tb_acc", n_acc, 16);
      check("tb_fields", {rsp_rdata, rsp_slverr, rsp_timeout}, {32'h0BAD_F00D, 2'b00});
      take("tb");
      // response back-pressure
      xfer("bp", 0, 32'h20, 32'h0, 1, 32'h1234_5678, 1, n_acc);
      held = rsp_rdata;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("bp_hold", {rsp_valid, cmd_ready, rsp_slverr, rsp_timeout, rsp_rdata}, {4'b1010, held});
      end
      check("bp_data", held, 32'h1234_5678);
      take("bp");
      // reset in ACCESS
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h30;
      tick();
      cmd_valid = 0;
      tick();
      check("ra_access", {psel, penable}, 2'b11);
      #2 rst = 1;
      #1 check("ra_async", {psel, penable, rsp_valid}, 3'b000);
      tick(); tick();
      rst = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("ra_norsp", {rsp_valid, psel, cmd_ready}, 3'b001);
      end
      xfer("rf", 0, 32'h34, 32'h0, 0, 32'h0000_0077, 0, n_acc);
      check("rf_fields", {rsp_rdata, rsp_slverr, rsp_timeout}, {32'h77, 2'b00});
      take("rf");
      // loopback: write a control register then read it back from the slave model
      xfer("lbw", 1, 32'h0C, 32'h0000_0083, 0, 32'h0, 0, n_acc);
      take("lbw");
      xfer("lbr", 0, 32'h0C, 32'h0, 1, last_wdata, 0, n_acc);
      check("lb_fields", {rsp_rdata, rsp_slverr, rsp_timeout}, {32'h83, 2'b00});
      take("lbr");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
